dh_exp_sequencer: RTL and testbench

// Sequences the shared modular-exponentiation engine for a Diffie-Hellman exchange. Holds prime p, generator g
// and private key a; on command it runs either PUB = g^a mod p or SHARED = B^a mod p (B = peer public key).

---
 rtl/dh_exp_sequencer.sv | 141 ++++++++++++++
 tb/tb_dh_exp_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dh_exp_sequencer.sv
// dh_exp_sequencer: sequences a shared modexp engine for Diffie-Hellman public/shared key computation.
module dh_exp_sequencer #(
  parameter int W = 100,
  parameter int EXP_W = 101,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load,
  input  logic [W-1:0]     cfg_prime,
  input  logic [W-1:0]     cfg_gen,
  input  logic [EXP_W-1:0] cfg_priv,
  output logic             cfg_ready,
  input  logic             cmd_valid,
  input  logic             cmd_op,
  input  logic [W-1:0]     cmd_peer,
  output logic             cmd_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_op,
  output logic [W-1:0]     rsp_data,
  output logic [1:0]       rsp_err,
  output logic             eng_start,
  output logic [W-1:0]     eng_base,
  output logic [EXP_W-1:0] eng_exp,
  output logic [W-1:0]     eng_prime,
  input  logic             eng_busy,
  input  logic [W-1:0]     eng_result
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  typedef enum logic [2:0] {IDLE, CHECK, START, ARM, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [W-1:0] prime_q, prime_d, gen_q, gen_d, peer_q, peer_d;
  logic [EXP_W-1:0] priv_q, priv_d;
  logic cfg_done_q, cfg_done_d, op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [W-1:0] rsp_data_q, rsp_data_d, base_q, base_d, eprime_q, eprime_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [1:0] rsp_err_q, rsp_err_d;
  logic bad_cfg, bad_peer;
  assign cfg_ready = state_q == IDLE;
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign eng_start = state_q == START;
  assign rsp_op    = op_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign eng_base  = base_q;
  assign eng_exp   = exp_q;
  assign eng_prime = eprime_q;
  assign cnt_inc   = cnt_q == TMAX ? cnt_q : cnt_q + CW'(1);
  assign bad_cfg   = !cfg_done_q || priv_q == '0 || prime_q < W'(5);
  // p-2 only matters once p>=5 has been established, so no underflow concern
  assign bad_peer  = op_q && (peer_q < W'(2) || peer_q > prime_q - W'(2));
  always_comb begin
    state_d = state_q;
    prime_d = prime_q;
    gen_d = gen_q;
    priv_d = priv_q;
    cfg_done_d = cfg_done_q;
    op_d = op_q;
    peer_d = peer_q;
    cnt_d = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    base_d = base_q;
    exp_d = exp_q;
    eprime_d = eprime_q;
    case (state_q)
      IDLE: begin
        if (cfg_load) begin
          prime_d = cfg_prime;
          gen_d = cfg_gen;
          priv_d = cfg_priv;
          cfg_done_d = 1'b1;
        end
        if (cmd_valid) begin
          op_d = cmd_op;
          peer_d = cmd_peer;
          state_d = CHECK;
        end
      end
      CHECK: begin
        state_d = bad_cfg || bad_peer ? RESP : START;
        rsp_data_d = '0;
        rsp_err_d = bad_cfg ? 2'd1 : bad_peer ? 2'd2 : 2'd0;
        base_d = bad_cfg || bad_peer ? base_q : op_q ? peer_q : gen_q;
        exp_d = bad_cfg || bad_peer ? exp_q : priv_q;
        eprime_d = bad_cfg || bad_peer ? eprime_q : prime_q;
      end
      START: begin
        state_d = ARM;
        cnt_d = '0;
      end
      ARM: begin
        state_d = WAIT;
        cnt_d = cnt_inc;
      end
      WAIT: begin
        cnt_d = cnt_inc;
        state_d = !eng_busy || cnt_inc == TMAX ? RESP : WAIT;
        rsp_data_d = !eng_busy ? eng_result : '0;
        rsp_err_d = !eng_busy ? 2'd0 : 2'd3;
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prime_q <= '0;
      gen_q <= '0;
      priv_q <= '0;
      cfg_done_q <= 1'b0;
      op_q <= 1'b0;
      peer_q <= '0;
      cnt_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q <= '0;
      base_q <= '0;
      exp_q <= '0;
      eprime_q <= '0;
    end else begin
      state_q <= state_d;
      prime_q <= prime_d;
      gen_q <= gen_d;
      priv_q <= priv_d;
      cfg_done_q <= cfg_done_d;
      op_q <= op_d;
      peer_q <= peer_d;
      cnt_q <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      base_q <= base_d;
      exp_q <= exp_d;
      eprime_q <= eprime_d;
    end
  end
endmodule

// File: tb/tb_dh_exp_sequencer.sv
// tb_dh_exp_sequencer: randomized bench with a behavioural modexp engine and DH reference model.
module tb_dh_exp_sequencer;
  localparam int W = 100;
  localparam int EXP_W = 101;
  localparam int TIMEOUT = 16;
  logic clk = 0, rst_n = 0;
  logic cfg_load = 0, cmd_valid = 0, cmd_op = 0, rsp_ready = 0;
  logic [W-1:0] cfg_prime = '0, cfg_gen = '0, cmd_peer = '0;
  logic [EXP_W-1:0] cfg_priv = '0;
  logic cfg_ready, cmd_ready, rsp_valid, rsp_op, eng_start;
  logic [W-1:0] rsp_data, eng_base, eng_prime;
  logic [EXP_W-1:0] eng_exp;
  logic [1:0] rsp_err;
  logic eng_busy = 0;
  logic [W-1:0] eng_result = '0;
  int checks = 0, errors = 0;
  int eng_lat = 3, eng_rem = 0, n_start = 0;
  logic eng_hang = 0, eng_rst = 0;
  logic [W-1:0] s_data;
  logic [1:0] s_err;
  logic s_op;
  int s_lat;
  dh_exp_sequencer #(.W(W), .EXP_W(EXP_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_prime(cfg_prime), .cfg_gen(cfg_gen),
    .cfg_priv(cfg_priv), .cfg_ready(cfg_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_peer(cmd_peer), .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_op(rsp_op), .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_start(eng_start),
    .eng_base(eng_base), .eng_exp(eng_exp), .eng_prime(eng_prime), .eng_busy(eng_busy),
    .eng_result(eng_result));
  always #5 clk = ~clk;
  function automatic longint modexp(longint b, longint e, longint p);
    longint r = 1;
    b = b % p;
    while (e > 0) begin
      if (e % 2 == 1) r = r * b % p;
      b = b * b % p;
      e = e / 2;
    end
    return r;
  endfunction
  always @(posedge clk) begin
    if (eng_start) n_start <= n_start + 1;
    if (eng_rst) begin
      eng_busy <= 0;
    end else if (eng_start) begin
      eng_busy <= 1;
      eng_rem <= eng_lat;
    end else if (eng_busy && !eng_hang) begin
      if (eng_rem == 1) begin
        eng_busy <= 0;
        eng_result <= W'(modexp(longint'(eng_base[31:0]), longint'(eng_exp[31:0]), longint'(eng_prime[31:0])));
      end else eng_rem <= eng_rem - 1;
    end
  end
  task automatic do_cfg(input int p, input int g, input int a);
    @(negedge clk);
    cfg_load = 1; cfg_prime = W'(p); cfg_gen = W'(g); cfg_priv = EXP_W'(a);
    @(negedge clk);
    cfg_load = 0;
  endtask
  task automatic run_cmd(input logic op, input int peer);
    @(negedge clk);
    n_start = 0;
    cmd_valid = 1; cmd_op = op; cmd_peer = W'(peer);
    @(negedge clk);
    cmd_valid = 0;
    s_lat = 1;
    while (!rsp_valid && s_lat < 200) begin
      @(negedge clk);
      s_lat++;
    end
    s_data = rsp_data; s_err = rsp_err; s_op = rsp_op;
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask
  task automatic eng_reset;
    @(negedge clk); eng_rst = 1;
    @(negedge clk); eng_rst = 0;
  endtask
  task automatic test_reset;
    rst_n = 0;
    #12;
    checks++;
    if (!cfg_ready || !cmd_ready || rsp_valid || rsp_op || rsp_data !== '0 || rsp_err !== 0 || eng_start ||
        eng_base !== '0 || eng_exp !== '0 || eng_prime !== '0) begin
      errors++; $display("FAIL reset_values got rdy=%b/%b v=%b err=%0d data=%0d", cfg_ready, cmd_ready, rsp_valid, rsp_err, rsp_data);
    end
    @(negedge clk); rst_n = 1;
  endtask
  task automatic test_pub;
    do_cfg(23, 5, 6);
    eng_lat = 3;
    run_cmd(0, 0);
    checks++; if (s_data !== W'(8)) begin errors++; $display("FAIL pub_data got %0d exp 8", s_data); end
    checks++; if (s_err !== 0 || s_op !== 0) begin errors++; $display("FAIL pub_err_op got %0d/%0d exp 0/0", s_err, s_op); end
    checks++; if (n_start != 1) begin errors++; $display("FAIL pub_starts got %0d exp 1", n_start); end
    checks++; if (eng_base !== W'(5) || eng_exp !== EXP_W'(6) || eng_prime !== W'(23)) begin
      errors++; $display("FAIL pub_eng_ops got %0d/%0d/%0d exp 5/6/23", eng_base, eng_exp, eng_prime); end
    checks++; if (s_lat != 7) begin errors++; $display("FAIL pub_latency got %0d exp 7", s_lat); end
  endtask
  task automatic test_shared;
    run_cmd(1, 19);
    checks++; if (s_data !== W'(2) || s_err !== 0 || s_op !== 1) begin
      errors++; $display("FAIL shared_rsp got %0d/%0d/%0d exp 2/0/1", s_data, s_err, s_op); end
    checks++; if (eng_base !== W'(19)) begin errors++; $display("FAIL shared_base got %0d exp 19", eng_base); end
  endtask
  task automatic test_bad_peer;
    int peers[2] = '{1, 22};
    foreach (peers[i]) begin
      run_cmd(1, peers[i]);
      checks++; if (s_err !== 2 || s_data !== '0 || n_start != 0 || s_lat != 2) begin
        errors++; $display("FAIL bad_peer_%0d got err=%0d data=%0d starts=%0d lat=%0d exp 2/0/0/2", peers[i], s_err, s_data, n_start, s_lat); end
    end
  endtask
  task automatic test_unconfigured;
    run_cmd(0, 0);
    checks++; if (s_err !== 1 || s_data !== '0 || n_start != 0 || s_lat != 2) begin
      errors++; $display("FAIL no_cfg got err=%0d data=%0d starts=%0d lat=%0d exp 1/0/0/2", s_err, s_data, n_start, s_lat); end
    do_cfg(23, 5, 0);
    run_cmd(0, 0);
    checks++; if (s_err !== 1 || n_start != 0) begin
      errors++; $display("FAIL zero_key got err=%0d starts=%0d exp 1/0", s_err, n_start); end
  endtask
  task automatic test_timeout;
    do_cfg(23, 5, 6);
    eng_hang = 1;
    run_cmd(0, 0);
    checks++; if (s_err !== 3 || s_data !== '0 || s_lat != 3 + TIMEOUT) begin
      errors++; $display("FAIL timeout got err=%0d data=%0d lat=%0d exp 3/0/%0d", s_err, s_data, s_lat, 3 + TIMEOUT); end
    checks++; if (!cmd_ready) begin errors++; $display("FAIL timeout_ready got 0 exp 1"); end
    eng_hang = 0;
    eng_reset();
  endtask
  task automatic test_backpressure;
    logic [W-1:0] d0;
    int bad = 0;
    eng_lat = 2;
    @(negedge clk); cmd_valid = 1; cmd_op = 1; cmd_peer = W'(19);
    @(negedge clk); cmd_valid = 0;
    for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge clk);
    d0 = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== d0 || rsp_op !== 1 || rsp_err !== 0 || cmd_ready || cfg_ready) bad++;
    end
    checks++; if (bad != 0 || d0 !== W'(2)) begin errors++; $display("FAIL backpressure got bad=%0d data=%0d exp 0/2", bad, d0); end
    rsp_ready = 1;
    @(negedge clk); rsp_ready = 0;
    checks++; if (rsp_valid || !cmd_ready) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0/1", rsp_valid, cmd_ready); end
  endtask
  task automatic test_random;
    int primes[6] = '{23, 29, 47, 101, 251, 65521};
    for (int n = 0; n < 40; n++) begin
      int p, g, a, b, e, l;
      logic op;
      longint exp_d;
      p = primes[$urandom_range(5)];
      g = $urandom_range(p - 1, 2);
      a = ($urandom_range(9) == 0) ? 0 : $urandom_range(500, 1);
      b = ($urandom_range(5) == 0) ? $urandom_range(1, 0) : $urandom_range(p - 2, 2);
      if ($urandom_range(7) == 0) b = p - 1;
      op = 1'($urandom_range(1));
      l = $urandom_range(8, 1);
      eng_lat = l;
      do_cfg(p, g, a);
      run_cmd(op, b);
      e = (a == 0) ? 1 : (op && (b < 2 || b > p - 2)) ? 2 : 0;
      exp_d = (e != 0) ? 0 : modexp(op ? b : g, a, p);
      checks++; if (s_err !== 2'(e) || s_data !== W'(exp_d) || s_op !== op || s_lat != ((e != 0) ? 2 : l + 4) || n_start != (e == 0)) begin
        errors++; $display("FAIL random_%0d p=%0d g=%0d a=%0d b=%0d op=%0d got err=%0d data=%0d lat=%0d starts=%0d exp err=%0d data=%0d",
                           n, p, g, a, b, op, s_err, s_data, s_lat, n_start, e, exp_d);
      end
    end
  endtask
  task automatic test_midreset;
    do_cfg(23, 5, 6);
    eng_lat = 8;
    @(negedge clk); cmd_valid = 1; cmd_op = 0;
    @(negedge clk); cmd_valid = 0;
    repeat (5) @(negedge clk);
    rst_n = 0;
    #1;
    checks++; if (!cmd_ready || rsp_valid || eng_start || eng_base !== '0 || eng_exp !== '0 || rsp_data !== '0) begin
      errors++; $display("FAIL midreset got rdy=%b v=%b base=%0d exp 1/0/0", cmd_ready, rsp_valid, eng_base); end
    eng_rst = 1;
    @(negedge clk); rst_n = 1;
    @(negedge clk); eng_rst = 0;
    run_cmd(0, 0);
    checks++; if (s_err !== 1) begin errors++; $display("FAIL post_reset_cfg got err=%0d exp 1", s_err); end
  endtask
  initial begin
    test_reset();
    test_unconfigured();
    test_pub();
    test_shared();
    test_bad_peer();
    test_timeout();
    test_backpressure();
    test_random();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
